stage5_fence_sequencer: RTL and testbench

Sequences the cache and TLB maintenance operations required by `FENCE.I` and `SFENCE.VMA` in the five-stage pipeline. It takes fence requests from the memory stage and orders the work: D-cache writeback/flush, then I-cache invalidate, then I-TLB and D-TLB fences. It drives single-cycle pulses into the cache-control interface, collects the done responses, and holds the pipeline with `fence_stall` until the sequence retires. It sits between the memory stage and `cache_control_if`, replacing the per-stage ad hoc pulse/flag logic.

---
 rtl/stage5_fence_if.sv | 26 ++
 rtl/stage5_fence_sequencer.sv | 153 +++++++++++++++
 tb/tb_stage5_fence_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/stage5_fence_if.sv
// Cache/TLB maintenance bundle between the fence sequencer (master) and the
// cache-control side (slave): single-cycle command pulses, sfence operands, done strobes.
interface stage5_fence_if #(
  parameter int ASID_LENGTH = 9
);
  logic                   dcache_flush;
  logic                   icache_flush;
  logic                   itlb_fence;
  logic                   dtlb_fence;
  logic [ASID_LENGTH-1:0] fence_asid;
  logic [31:0]            fence_va;
  logic                   dflush_done;
  logic                   iflush_done;
  logic                   itlb_fence_done;
  logic                   dtlb_fence_done;

  modport master (
    output dcache_flush, icache_flush, itlb_fence, dtlb_fence, fence_asid, fence_va,
    input  dflush_done, iflush_done, itlb_fence_done, dtlb_fence_done
  );

  modport slave (
    input  dcache_flush, icache_flush, itlb_fence, dtlb_fence, fence_asid, fence_va,
    output dflush_done, iflush_done, itlb_fence_done, dtlb_fence_done
  );
endinterface

// File: rtl/stage5_fence_sequencer.sv
// Orders FENCE.I / SFENCE.VMA maintenance: D-cache flush, I-cache invalidate, TLB fences.
// Optional watchdog enabled by defining STAGE5_FENCE_TIMEOUT_EN.
module stage5_fence_sequencer #(
  parameter int ASID_LENGTH    = 9,
  parameter bit TLB_PRESENT    = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ifence_req,
  input  logic                   sfence_req,
  input  logic                   ex_mem_stall,
  input  logic [ASID_LENGTH-1:0] req_asid,
  input  logic [31:0]            req_va,
  stage5_fence_if.master         cc,
  output logic                   fence_stall,
  output logic                   fence_done,
  output logic                   fence_timeout
);

  typedef enum logic [2:0] {IDLE, DFLUSH, IFLUSH, TLB, DONE} state_t;

  state_t                 state, state_n;
  logic                   pend_s;
  logic                   it_ok, dt_ok;
  logic                   dflush_q, iflush_q, tlb_q;
  logic [ASID_LENGTH-1:0] asid_q;
  logic [31:0]            va_q;
  logic                   tlb_both;
  logic                   phase_done;
  logic                   waiting;
  logic                   entering;
  logic                   wd_hit;

  assign tlb_both = (it_ok || cc.itlb_fence_done) && (dt_ok || cc.dtlb_fence_done);
  assign waiting  = (state == DFLUSH) || (state == IFLUSH) || (state == TLB);
  assign entering = (state_n != state) &&
                    ((state_n == DFLUSH) || (state_n == IFLUSH) || (state_n == TLB));

  always_comb begin
    phase_done = 1'b0;
    case (state)
      DFLUSH:  phase_done = cc.dflush_done;
      IFLUSH:  phase_done = cc.iflush_done;
      TLB:     phase_done = tlb_both;
      default: phase_done = 1'b0;
    endcase
  end

`ifdef STAGE5_FENCE_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
  logic        timeout_q;

  // The registered timeout pulse doubles as the synthetic done for the stuck phase.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= waiting && !phase_done && !timeout_q && (wd_cnt == WD_LAST);
      if (entering)
        wd_cnt <= '0;
      else if (waiting)
        wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign wd_hit        = timeout_q;
  assign fence_timeout = timeout_q;
`else
  assign wd_hit        = 1'b0;
  assign fence_timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    fence_stall = 1'b0;
    fence_done  = 1'b0;
    case (state)
      IDLE: begin
        fence_stall = ifence_req || sfence_req;
        if (ifence_req)
          state_n = DFLUSH;
        else if (sfence_req)
          state_n = (TLB_PRESENT != 1'b0) ? TLB : DONE;
      end
      DFLUSH: begin
        fence_stall = 1'b1;
        if (phase_done || wd_hit)
          state_n = IFLUSH;
      end
      IFLUSH: begin
        fence_stall = 1'b1;
        if (phase_done || wd_hit)
          state_n = (pend_s && (TLB_PRESENT != 1'b0)) ? TLB : DONE;
      end
      TLB: begin
        fence_stall = 1'b1;
        if (phase_done || wd_hit)
          state_n = DONE;
      end
      DONE: begin
        fence_done = 1'b1;
        // Leave only once the pipeline advances, so a still-held request cannot re-fire.
        if (!ex_mem_stall)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      pend_s   <= 1'b0;
      it_ok    <= 1'b0;
      dt_ok    <= 1'b0;
      dflush_q <= 1'b0;
      iflush_q <= 1'b0;
      tlb_q    <= 1'b0;
      asid_q   <= '0;
      va_q     <= '0;
    end else begin
      state    <= state_n;
      // Command pulses fire in the first cycle of the state they belong to.
      dflush_q <= (state_n == DFLUSH) && (state != DFLUSH);
      iflush_q <= (state_n == IFLUSH) && (state != IFLUSH);
      tlb_q    <= (state_n == TLB)    && (state != TLB);
      if ((state == IDLE) && ifence_req)
        pend_s <= sfence_req;
      if ((state == IDLE) && sfence_req) begin
        asid_q <= req_asid;
        va_q   <= req_va;
      end
      if (state == TLB) begin
        it_ok <= it_ok || cc.itlb_fence_done;
        dt_ok <= dt_ok || cc.dtlb_fence_done;
      end else begin
        it_ok <= 1'b0;
        dt_ok <= 1'b0;
      end
    end
  end

  assign cc.dcache_flush = dflush_q;
  assign cc.icache_flush = iflush_q;
  assign cc.itlb_fence   = tlb_q;
  assign cc.dtlb_fence   = tlb_q;
  assign cc.fence_asid   = asid_q;
  assign cc.fence_va     = va_q;

endmodule

// File: tb/tb_stage5_fence_sequencer.sv
// Bench for stage5_fence_sequencer: directed and randomized fence sequences checked
// against an event-timeline model derived from the phase/done timing rules.
module tb_stage5_fence_sequencer;
  localparam int AW = 9;
  localparam int TO = 8;
`ifdef STAGE5_FENCE_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ifence_req, sfence_req, ex_mem_stall;
  logic [AW-1:0] req_asid;
  logic [31:0]   req_va;
  logic          fence_stall, fence_done, fence_timeout;

  int total = 0;
  int bad   = 0;

  stage5_fence_if #(.ASID_LENGTH(AW)) cc ();

  stage5_fence_sequencer #(
    .ASID_LENGTH(AW), .TLB_PRESENT(1'b1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .ifence_req(ifence_req), .sfence_req(sfence_req), .ex_mem_stall(ex_mem_stall),
    .req_asid(req_asid), .req_va(req_va),
    .cc(cc),
    .fence_stall(fence_stall), .fence_done(fence_done), .fence_timeout(fence_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Effective wait of a phase: the real done delay, capped by the watchdog when built.
  function automatic int eff(input int dly);
    if (WD && dly >= TO) return TO;
    return dly;
  endfunction

  // Run one fence from the IDLE request cycle (c=0) through return to IDLE.
  // Delays count cycles from the phase's pulse cycle to its done strobe.
  task automatic run_seq(input string name, input bit ifn, input bit sfn,
                         input int dd, input int id, input int itd, input int dtd,
                         input int hold, input logic [AW-1:0] a, input logic [31:0] v);
    int dstart, istart, tstart, after, d_end, m;
    int to1, to2, to3;
    dstart = -1; istart = -1; tstart = -1; to1 = -1; to2 = -1; to3 = -1;
    if (ifn) begin
      dstart = 1;
      if (WD && dd >= TO) to1 = dstart + TO;
      istart = dstart + eff(dd) + 1;
      if (WD && id >= TO) to2 = istart + TO;
      after = istart + eff(id) + 1;
    end else begin
      after = 1;
    end
    if (sfn) begin
      tstart = after;
      m = (itd > dtd) ? itd : dtd;
      if (WD && m >= TO) to3 = tstart + TO;
      d_end = tstart + eff(m) + 1;
    end else begin
      d_end = after;
    end

    for (int c = 0; c <= d_end + hold + 1; c++) begin
      @(negedge CLK);
      ifence_req   = ifn && (c < d_end + hold);
      sfence_req   = sfn && (c < d_end + hold);
      ex_mem_stall = (c >= d_end && c < d_end + hold) ? 1'b1 :
                     (c < d_end) ? 1'($urandom) : 1'b0;
      req_asid     = (c == 0) ? a : AW'($urandom);
      req_va       = (c == 0) ? v : $urandom;
      cc.dflush_done     = ifn && (c == dstart + dd);
      cc.iflush_done     = ifn && (c == istart + id);
      cc.itlb_fence_done = sfn && (c == tstart + itd);
      cc.dtlb_fence_done = sfn && (c == tstart + dtd);
      #1;
      chk({name, ".dcache_flush"}, cc.dcache_flush, c == dstart);
      chk({name, ".icache_flush"}, cc.icache_flush, c == istart);
      chk({name, ".itlb_fence"},   cc.itlb_fence,   c == tstart);
      chk({name, ".dtlb_fence"},   cc.dtlb_fence,   c == tstart);
      chk({name, ".fence_stall"},  fence_stall,     c < d_end);
      chk({name, ".fence_done"},   fence_done,      c >= d_end && c <= d_end + hold);
      chk({name, ".fence_timeout"}, fence_timeout,  c == to1 || c == to2 || c == to3);
      if (sfn && c >= 1 && c <= d_end) begin
        chk({name, ".fence_asid"}, cc.fence_asid, a);
        chk({name, ".fence_va"},   cc.fence_va,   v);
      end
    end
    cc.dflush_done = 1'b0; cc.iflush_done = 1'b0;
    cc.itlb_fence_done = 1'b0; cc.dtlb_fence_done = 1'b0;
  endtask

  initial begin
    bit ri, rs;
    nRST = 1'b0;
    ifence_req = 1'b0; sfence_req = 1'b0; ex_mem_stall = 1'b0;
    req_asid = '0; req_va = '0;
    cc.dflush_done = 1'b0; cc.iflush_done = 1'b0;
    cc.itlb_fence_done = 1'b0; cc.dtlb_fence_done = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst.dcache_flush", cc.dcache_flush, 0);
    chk("rst.icache_flush", cc.icache_flush, 0);
    chk("rst.tlb_fence", {cc.itlb_fence, cc.dtlb_fence}, 0);
    chk("rst.fence_stall", fence_stall, 0);
    chk("rst.fence_done", fence_done, 0);
    chk("rst.fence_timeout", fence_timeout, 0);
    chk("rst.fence_asid", cc.fence_asid, 0);
    chk("rst.fence_va", cc.fence_va, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Stray done while idle must not start anything
    @(negedge CLK);
    cc.dflush_done = 1'b1; cc.iflush_done = 1'b1;
    @(negedge CLK);
    cc.dflush_done = 1'b0; cc.iflush_done = 1'b0;
    #1;
    chk("stray.dcache_flush", cc.dcache_flush, 0);
    chk("stray.icache_flush", cc.icache_flush, 0);
    chk("stray.fence_done", fence_done, 0);

    // Directed scenarios
    run_seq("fencei_delayed", 1'b1, 1'b0, 3, 2, 0, 0, 0, 9'h055, 32'h1234_5678);
    run_seq("sfence_split", 1'b0, 1'b1, 0, 0, 1, 4, 0, 9'h1A5, 32'h8000_1000);
    run_seq("combined", 1'b1, 1'b1, 0, 0, 0, 0, 0, 9'h0F0, 32'hDEAD_BEEF);
    run_seq("held_done", 1'b1, 1'b0, 0, 0, 0, 0, 3, 9'h000, 32'h0);
    run_seq("sfence_same", 1'b0, 1'b1, 0, 0, 0, 0, 1, 9'h1FF, 32'hFFFF_FFFC);

    // Reset mid-sequence, while waiting in IFLUSH
    @(negedge CLK);
    ifence_req = 1'b1;
    @(negedge CLK);
    cc.dflush_done = 1'b1;
    @(negedge CLK);
    cc.dflush_done = 1'b0;
    #1;
    chk("rstmid.icache_pulse", cc.icache_flush, 1);
    @(negedge CLK);
    #1;
    chk("rstmid.stall_before", fence_stall, 1);
    nRST = 1'b0;
    ifence_req = 1'b0;
    #1;
    chk("rstmid.icache_flush", cc.icache_flush, 0);
    chk("rstmid.dcache_flush", cc.dcache_flush, 0);
    chk("rstmid.fence_stall", fence_stall, 0);
    chk("rstmid.fence_done", fence_done, 0);
    chk("rstmid.fence_timeout", fence_timeout, 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      cc.iflush_done = (k == 1);
      #1;
      chk("postrst.icache_flush", cc.icache_flush, 0);
      chk("postrst.fence_stall", fence_stall, 0);
      chk("postrst.fence_done", fence_done, 0);
    end
    cc.iflush_done = 1'b0;

`ifdef STAGE5_FENCE_TIMEOUT_EN
    // Watchdog: D-cache never answers; then a TLB fence with one side stuck
    run_seq("wdog_dflush", 1'b1, 1'b0, 40, 1, 0, 0, 0, 9'h011, 32'h0000_4000);
    run_seq("wdog_tlb", 1'b0, 1'b1, 0, 0, 2, 40, 0, 9'h122, 32'h0000_8000);
`endif

    // Randomized sequences
    for (int n = 0; n < 24; n++) begin
      ri = 1'($urandom);
      rs = ri ? 1'($urandom) : 1'b1;
      run_seq("rand", ri, rs,
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), AW'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
